// File: rtl/tanh_grad.sv
// Purpose    : tanh backward pass, dx = g * (1 - y^2), all values signed Q6.9.
// Latency    : 3 cycles from input acceptance to dx valid; throughput 1 per cycle.
// Backpressure: one global advance (~out_valid | out_ready) freezes every stage; in_ready follows it.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   y/g handshake
//   y, g                forward tanh output and upstream gradient (Q6.9)
//   out_valid/out_ready dx handshake
//   dx                  input gradient (Q6.9)
//   count               completed dx transfers since reset, wraps at 16 bits
module tanh_grad (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] y,
    input  logic signed [15:0] g,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] dx,
    output logic        [15:0] count
);

    localparam logic signed [15:0] ONE     = 16'sh0200;
    localparam logic signed [15:0] NEG_ONE = 16'shFE00;

    logic adv;

    // S1: clamped y and registered g
    logic               v1_q, v1_d;
    logic signed [15:0] yc_q, yc_d;
    logic signed [15:0] g1_q, g1_d;
    // S2: d = 1 - y^2 and g
    logic               v2_q, v2_d;
    logic signed [15:0] d_q, d_d;
    logic signed [15:0] g2_q, g2_d;
    // S3: result
    logic               v3_q, v3_d;
    logic signed [15:0] dx_q, dx_d;

    logic        [15:0] count_q, count_d;

    logic signed [31:0] sq;
    logic signed [31:0] prod;

    always_comb begin
        adv = ~v3_q | out_ready;
        // Pipeline is empty while reset is held, so advertise readiness even
        // on the first reset cycle; the reset branch of the register block
        // guarantees nothing is captured.
        in_ready = adv | ~rst;

        // Arithmetic is computed every cycle; only the load is gated.
        sq   = 32'(yc_q) * 32'(yc_q);
        prod = 32'(g2_q) * 32'(d_q);

        v1_d    = v1_q;
        yc_d    = yc_q;
        g1_d    = g1_q;
        v2_d    = v2_q;
        d_d     = d_q;
        g2_d    = g2_q;
        v3_d    = v3_q;
        dx_d    = dx_q;
        count_d = count_q + {15'd0, v3_q & out_ready};

        if (adv) begin
            v1_d = in_valid;
            if (y > ONE) begin
                yc_d = ONE;
            end else if (y < NEG_ONE) begin
                yc_d = NEG_ONE;
            end else begin
                yc_d = y;
            end
            g1_d = g;

            // yc in [-1,1] so y^2 in [0,1] and d fits comfortably in 16 bits.
            v2_d = v1_q;
            d_d  = 16'(32'sh0000_0200 - (sq >>> 9));
            g2_d = g1_q;

            // d in [0,1] means |dx| <= |g|: truncation cannot overflow.
            v3_d = v2_q;
            dx_d = 16'(prod >>> 9);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            yc_q    <= '0;
            g1_q    <= '0;
            v2_q    <= 1'b0;
            d_q     <= '0;
            g2_q    <= '0;
            v3_q    <= 1'b0;
            dx_q    <= '0;
            count_q <= '0;
        end else begin
            v1_q    <= v1_d;
            yc_q    <= yc_d;
            g1_q    <= g1_d;
            v2_q    <= v2_d;
            d_q     <= d_d;
            g2_q    <= g2_d;
            v3_q    <= v3_d;
            dx_q    <= dx_d;
            count_q <= count_d;
        end
    end

    assign out_valid = v3_q;
    assign dx        = dx_q;
    assign count     = count_q;

endmodule

// File: tb/tb_tanh_grad.sv
// Purpose    : self-checking bench for tanh_grad using hand-computed vectors.
// Latency    : expects dx three cycles after acceptance with out_ready high.
// Backpressure: exercises a stall window, mid-stream reset and counter wrap.
module tb_tanh_grad;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] y;
    logic signed [15:0] g;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dx;
    logic        [15:0] count;

    tanh_grad dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .g        (g),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dx       (dx),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [15:0] g;
        logic [15:0] dx;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int total_cnt;
    int pass_cnt;
    logic [15:0] exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        exp_count = 16'h0000;
    endtask

    initial begin
        // y, g, expected dx (Q6.9, floor shifts)
        vecs[0]  = '{16'h0000, 16'h0200, 16'h0200};
        vecs[1]  = '{16'h0100, 16'h0200, 16'h0180};
        vecs[2]  = '{16'hFF00, 16'hFE00, 16'hFE80};
        vecs[3]  = '{16'h0400, 16'h1234, 16'h0000};
        vecs[4]  = '{16'h0200, 16'h7FFF, 16'h0000};
        vecs[5]  = '{16'h0000, 16'h7FFF, 16'h7FFF};
        vecs[6]  = '{16'h8000, 16'h0200, 16'h0000};
        vecs[7]  = '{16'h0001, 16'h0200, 16'h0200};
        vecs[8]  = '{16'h00C0, 16'h0300, 16'h0294};
        vecs[9]  = '{16'h0100, 16'hFFFF, 16'hFFFF};
        vecs[10] = '{16'h0100, 16'h0001, 16'h0000};
        vecs[11] = '{16'h0180, 16'hFC00, 16'hFE40};

        total_cnt = 0;
        pass_cnt  = 0;
        exp_count = 16'h0000;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        y         = '0;
        g         = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_count", {16'd0, count}, 32'd0);
        check("reset_dx", {16'd0, dx}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;

        // ---------------- single item, exact latency ----------------
        @(negedge clk);
        y = 16'h0000; g = 16'h0200; in_valid = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("lat_valid_c%0d", j), {31'd0, out_valid}, {31'd0, (j == 3)});
        end
        check("lat_dx", {16'd0, dx}, 32'h0200);
        @(negedge clk);
        #1;
        exp_count = 16'd1;
        check("lat_count", {16'd0, count}, {16'd0, exp_count});
        check("lat_drained", {31'd0, out_valid}, 32'd0);

        // ---------------- table, back-to-back ----------------
        for (int k = 0; k < NV + 3; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                #1;
                check($sformatf("tbl_valid_%0d", k - 3), {31'd0, out_valid}, 32'd1);
                check($sformatf("tbl_dx_%0d", k - 3), {16'd0, dx}, {16'd0, vecs[k - 3].dx});
                exp_count++;
            end
            if (k < NV) begin
                in_valid = 1'b1;
                y = vecs[k].y;
                g = vecs[k].g;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        check("tbl_count", {16'd0, count}, {16'd0, exp_count});

        // ---------------- stall window, 6 items ----------------
        do_reset();
        begin
            int in_idx;
            int out_idx;
            logic held;
            logic [15:0] held_dx;
            in_idx  = 0;
            out_idx = 0;
            held    = 1'b0;
            held_dx = '0;
            for (int cyc = 0; cyc < 30; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 4 && cyc <= 8);
                if (in_idx < 6) begin
                    in_valid = 1'b1;
                    y = vecs[in_idx].y;
                    g = vecs[in_idx].g;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (held) begin
                    check($sformatf("stall_hold_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
                    check($sformatf("stall_hold_dx_c%0d", cyc), {16'd0, dx}, {16'd0, held_dx});
                end
                held = 1'b0;
                if (out_valid && !out_ready) begin
                    check($sformatf("stall_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
                    held    = 1'b1;
                    held_dx = dx;
                end
                if (out_valid && out_ready) begin
                    if (out_idx < 6) begin
                        check($sformatf("stall_dx_%0d", out_idx), {16'd0, dx}, {16'd0, vecs[out_idx].dx});
                    end else begin
                        check("stall_extra_output", 32'd1, 32'd0);
                    end
                    out_idx++;
                    exp_count++;
                end
                if (in_valid && in_ready) in_idx++;
            end
            out_ready = 1'b1;
            check("stall_out_total", out_idx, 32'd6);
            #1;
            check("stall_count", {16'd0, count}, 32'd6);
        end

        // ---------------- reset with items in flight ----------------
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; y = 16'h0000; g = 16'h0100;
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flight_full", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_count", {16'd0, count}, 32'd0);
        rst = 1'b1;
        exp_count = 16'd0;
        in_valid = 1'b1; y = 16'h0100; g = 16'h0200;
        begin
            int n_valid;
            n_valid = 0;
            for (int j = 1; j <= 6; j++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid) begin
                    n_valid++;
                    check($sformatf("post_rst_cycle_c%0d", j), j, 32'd3);
                    check("post_rst_dx", {16'd0, dx}, 32'h0180);
                end
            end
            check("post_rst_outputs", n_valid, 32'd1);
            check("post_rst_count", {16'd0, count}, 32'd1);
        end

        // ---------------- count wrap ----------------
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; y = 16'h0000; g = 16'h0200;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("wrap_pre", {16'd0, count}, 32'hFFFF);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("wrap_post", {16'd0, count}, 32'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
